// File: rtl/mips_sim_pkg.sv
// mips_sim_pkg: shared run-state encoding and constants for the MIPS_MC run monitor.
package mips_sim_pkg;
   typedef enum logic [2:0] {HOLD, RUN, PASS, FAIL, TMO} run_state_t;
   localparam int PASS_VALUE = 1;
   localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_00FC;
endpackage

// File: rtl/wr_log_buf.sv
// wr_log_buf: keeps the first N_WATCH writes; later writes are dropped once full.
module wr_log_buf #(
   parameter int N_WATCH = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [$clog2(N_WATCH)-1:0] rd_idx,
   output logic                       full,
   output logic [ADDR_W-1:0]          rd_addr,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid
);
   logic [ADDR_W-1:0]          addr_q [N_WATCH];
   logic [ADDR_W-1:0]          addr_d [N_WATCH];
   logic [DATA_W-1:0]          data_q [N_WATCH];
   logic [DATA_W-1:0]          data_d [N_WATCH];
   logic [N_WATCH-1:0]         valid_q, valid_d;
   logic [$clog2(N_WATCH)-1:0] ptr_q, ptr_d;

   // Entries fill in order, so the log is full exactly when every slot is valid.
   assign full     = &valid_q;
   assign rd_addr  = addr_q[rd_idx];
   assign rd_data  = data_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (wr_en && !full) begin
         addr_d[ptr_q]  = wr_addr;
         data_d[ptr_q]  = wr_data;
         valid_d[ptr_q] = 1'b1;
         ptr_d          = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '{default: '0};
         data_q  <= '{default: '0};
         valid_q <= '0;
         ptr_q   <= '0;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end
endmodule

// File: rtl/mips_run_monitor.sv
// mips_run_monitor: sequences MIPS_MC reset, watches data-memory stores and ends the run
// on a tohost store (pass/fail) or a cycle timeout.
module mips_run_monitor
   import mips_sim_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                RST_CYCLES  = 2,
   parameter int                MAX_CYCLES  = 604,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_DEFAULT),
   parameter int                N_WATCH     = 4,
   parameter int                CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mem_we,
   input  logic [ADDR_W-1:0]          mem_addr,
   input  logic [DATA_W-1:0]          mem_wdata,
   output logic                       dut_reset,
   output logic                       running,
   output logic                       done,
   output logic                       pass,
   output logic                       fail,
   output logic                       timeout,
   output logic [DATA_W-2:0]          fail_code,
   output logic [CNT_W-1:0]           cycle_count,
   output logic [CNT_W-1:0]           write_count,
   output logic                       log_overflow,
   input  logic [$clog2(N_WATCH)-1:0] log_rd_idx,
   output logic [ADDR_W-1:0]          log_rd_addr,
   output logic [DATA_W-1:0]          log_rd_data,
   output logic                       log_valid
);
   localparam int HW = $clog2(RST_CYCLES) + 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

   run_state_t        state_q, state_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d, wcnt_q, wcnt_d;
   logic              pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d, ovf_q, ovf_d;
   logic [DATA_W-2:0] code_q, code_d;
   logic              in_run, tohost, store, log_we, log_full;

   assign in_run = state_q == RUN;
   assign tohost = in_run && mem_we && mem_addr == TOHOST_ADDR;
   assign store  = in_run && mem_we && mem_addr != TOHOST_ADDR;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cycle_d = cycle_q;
      wcnt_d  = wcnt_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      tmo_d   = tmo_q;
      ovf_d   = ovf_q;
      code_d  = code_q;
      log_we  = 1'b0;
      if (state_q == HOLD) begin
         hold_d  = hold_q + 1'b1;
         state_d = hold_q == HOLD_LAST ? RUN : HOLD;
      end else if (in_run) begin
         // A tohost store takes priority over a timeout landing in the same cycle.
         if (tohost) begin
            if (mem_wdata == DATA_W'(PASS_VALUE)) begin
               state_d = PASS;
               pass_d  = 1'b1;
            end else begin
               state_d = FAIL;
               fail_d  = 1'b1;
               code_d  = mem_wdata[DATA_W-1:1];
            end
         end else if (cycle_q == CYC_LAST) begin
            state_d = TMO;
            tmo_d   = 1'b1;
         end else begin
            cycle_d = cycle_q + 1'b1;
         end
         if (store) begin
            wcnt_d = &wcnt_q ? wcnt_q : wcnt_q + 1'b1;
            log_we = !log_full;
            ovf_d  = ovf_q | log_full;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HOLD;
         hold_q  <= '0;
         cycle_q <= '0;
         wcnt_q  <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         tmo_q   <= 1'b0;
         ovf_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cycle_q <= cycle_d;
         wcnt_q  <= wcnt_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         tmo_q   <= tmo_d;
         ovf_q   <= ovf_d;
         code_q  <= code_d;
      end
   end

   assign dut_reset    = state_q == HOLD;
   assign running      = in_run;
   assign done         = state_q == PASS || state_q == FAIL || state_q == TMO;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign timeout      = tmo_q;
   assign fail_code    = code_q;
   assign cycle_count  = cycle_q;
   assign write_count  = wcnt_q;
   assign log_overflow = ovf_q;

   wr_log_buf #(
      .N_WATCH(N_WATCH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_log (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (log_we),
      .wr_addr (mem_addr),
      .wr_data (mem_wdata),
      .rd_idx  (log_rd_idx),
      .full    (log_full),
      .rd_addr (log_rd_addr),
      .rd_data (log_rd_data),
      .rd_valid(log_valid)
   );
endmodule

// File: tb/tb_mips_run_monitor.sv
// tb_mips_run_monitor: random and directed stores checked every cycle against a
// time-based run model, plus literal checks of the key scenarios.
module tb_mips_run_monitor;
   localparam int AW = 32, DW = 32, RSTC = 2, MAXC = 20, NW = 4, CW = 16;
   localparam logic [31:0] TOHOST = 32'h0000_00FC;

   logic          clk = 1'b0, reset = 1'b0, mem_we = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic [1:0]    log_rd_idx = '0;
   logic          dut_reset, running, done, pass, fail, timeout, log_overflow, log_valid;
   logic [DW-2:0] fail_code;
   logic [CW-1:0] cycle_count, write_count;
   logic [AW-1:0] log_rd_addr;
   logic [DW-1:0] log_rd_data;

   int total = 0, bad = 0;

   mips_run_monitor #(
      .ADDR_W(AW), .DATA_W(DW), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
      .TOHOST_ADDR(TOHOST), .N_WATCH(NW), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .dut_reset(dut_reset), .running(running), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .fail_code(fail_code), .cycle_count(cycle_count),
      .write_count(write_count), .log_overflow(log_overflow), .log_rd_idx(log_rd_idx),
      .log_rd_addr(log_rd_addr), .log_rd_data(log_rd_data), .log_valid(log_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: t counts cycles since reset released and stops once the run ends.
   int t, mwc;
   bit mvalid = 0, term, mp, mf, mt, mo;
   logic [30:0] mcode;
   logic [31:0] la[$], ld[$];

   always @(posedge clk) begin
      if (reset) begin
         mvalid = 1; t = 0; term = 0; mp = 0; mf = 0; mt = 0; mo = 0; mcode = '0; mwc = 0;
         la.delete(); ld.delete();
      end else if (mvalid) begin
         if (!term && t >= RSTC) begin
            if (mem_we && mem_addr == TOHOST) begin
               term = 1;
               if (mem_wdata == 1) mp = 1;
               else begin mf = 1; mcode = mem_wdata[31:1]; end
            end else begin
               if (mem_we) begin
                  if (mwc < 65535) mwc++;
                  if (la.size() < NW) begin la.push_back(mem_addr); ld.push_back(mem_wdata); end
                  else mo = 1;
               end
               if (t - RSTC == MAXC - 1) begin term = 1; mt = 1; end
            end
         end
         if (!term) t++;
      end
   end

   always @(posedge clk) begin
      #1;
      if (mvalid) begin
         chk("dut_reset", dut_reset, !term && t < RSTC);
         chk("running", running, !term && t >= RSTC);
         chk("done", done, term);
         chk("pass", pass, mp);
         chk("fail", fail, mf);
         chk("timeout", timeout, mt);
         chk("fail_code", fail_code, mcode);
         chk("cycle_count", cycle_count, t >= RSTC ? t - RSTC : 0);
         chk("write_count", write_count, mwc);
         chk("log_overflow", log_overflow, mo);
         chk("log_valid", log_valid, int'(log_rd_idx) < la.size());
         if (int'(log_rd_idx) < la.size()) begin
            chk("log_addr", log_rd_addr, la[log_rd_idx]);
            chk("log_data", log_rd_data, ld[log_rd_idx]);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1; mem_we = 0;
      @(negedge clk);
      reset = 0;
   endtask

   task automatic start_run();
      do_reset();
      repeat (RSTC) @(negedge clk);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_we = 1; mem_addr = a; mem_wdata = d;
      @(negedge clk);
      mem_we = 0;
   endtask

   initial begin
      // Reset sequencing, store in HOLD ignored
      do_reset();
      chk("rst_dut_reset", dut_reset, 1);
      chk("rst_cycle", cycle_count, 0);
      chk("rst_done", done, 0);
      store(32'h40, 32'h55);
      chk("hold_dut_reset", dut_reset, 1);
      chk("hold_running", running, 0);
      @(negedge clk);
      chk("run_dut_reset", dut_reset, 0);
      chk("run_running", running, 1);
      chk("run_cycle0", cycle_count, 0);
      chk("hold_store_ignored", write_count, 0);
      // Pass at RUN cycle 10, then frozen
      repeat (10) @(negedge clk);
      chk("pre_pass_cycle", cycle_count, 10);
      store(TOHOST, 32'h1);
      chk("pass_flag", pass, 1);
      chk("pass_done", done, 1);
      chk("pass_cycle", cycle_count, 10);
      for (int i = 0; i < 50; i++) store({$urandom_range(0, 63), 2'b00}, $urandom);
      chk("pass_frozen_cycle", cycle_count, 10);
      chk("pass_frozen_wc", write_count, 0);
      chk("pass_still", pass, 1);
      // Fail with code
      start_run();
      repeat (3) @(negedge clk);
      store(TOHOST, 32'h7);
      chk("fail_flag", fail, 1);
      chk("fail_code", fail_code, 3);
      chk("fail_pass", pass, 0);
      chk("fail_tmo", timeout, 0);
      // Timeout
      start_run();
      for (int i = 0; i < 100 && !done; i++) @(negedge clk);
      chk("tmo_reached", done, 1);
      chk("tmo_flag", timeout, 1);
      chk("tmo_cycle", cycle_count, MAXC - 1);
      chk("tmo_pass", pass, 0);
      chk("tmo_fail", fail, 0);
      // Log overflow
      start_run();
      for (int i = 0; i < 6; i++) store(32'h10 + 4 * i, 32'hA + i);
      chk("log_wc", write_count, 6);
      chk("log_ovf", log_overflow, 1);
      for (int i = 0; i < NW; i++) begin
         log_rd_idx = 2'(i);
         #1;
         chk("log_v", log_valid, 1);
         chk("log_a", log_rd_addr, 32'h10 + 4 * i);
         chk("log_d", log_rd_data, 32'hA + i);
      end
      // Tohost store coincides with the last budget cycle
      start_run();
      repeat (MAXC - 1) @(negedge clk);
      chk("edge_cycle", cycle_count, MAXC - 1);
      store(TOHOST, 32'h1);
      chk("edge_pass", pass, 1);
      chk("edge_tmo", timeout, 0);
      // Reset mid-RUN
      start_run();
      store(32'h20, 32'h99);
      store(32'h24, 32'h98);
      repeat (3) @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("mid_dut_reset", dut_reset, 1);
      chk("mid_running", running, 0);
      chk("mid_done", done, 0);
      chk("mid_cycle", cycle_count, 0);
      chk("mid_wc", write_count, 0);
      for (int i = 0; i < NW; i++) begin
         log_rd_idx = 2'(i);
         #1;
         chk("mid_log_v", log_valid, 0);
      end
      reset = 0;
      // Random runs, checked by the per-cycle model compare
      for (int r = 0; r < 12; r++) begin
         start_run();
         for (int c = 0; c < 40; c++) begin
            mem_we = $urandom_range(0, 99) < 40;
            mem_addr = $urandom_range(0, 20) == 0 ? TOHOST : {$urandom_range(0, 63), 2'b00};
            mem_wdata = $urandom_range(0, 2) == 0 ? 32'h1 : $urandom;
            log_rd_idx = 2'($urandom_range(0, 3));
            reset = $urandom_range(0, 99) == 0;
            @(negedge clk);
         end
         mem_we = 0; reset = 0;
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
